// File: rtl/num_ascii_serializer_pkg.sv
// Shared types and constants for the number-to-ASCII read-back path.
// NUM_SER_CRLF_EN adds the CR/LF tail states to the state enum.
package num_ser_pkg;

    localparam int unsigned BCD_DIGITS = 10;
    localparam int unsigned BCD_WIDTH  = 4 * BCD_DIGITS;
    localparam int unsigned CONV_BITS  = 32;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_LOAD,
        ST_CONV,
        ST_EMIT_SIGN,
        ST_EMIT_DIG,
        ST_EMIT_SEP
`ifdef NUM_SER_CRLF_EN
        ,
        ST_TAIL_CR,
        ST_TAIL_LF
`endif
    } state_t;

    // Double-dabble correction: add 3 to every BCD digit that is 5 or more
    function automatic logic [BCD_WIDTH-1:0] dabble_adjust(input logic [BCD_WIDTH-1:0] i_bcd);
        logic [BCD_WIDTH-1:0] adj;
        adj = i_bcd;
        for (int unsigned d = 0; d < BCD_DIGITS; d++) begin
            if (adj[4*d +: 4] >= 4'd5) begin
                adj[4*d +: 4] = adj[4*d +: 4] + 4'd3;
            end
        end
        return adj;
    endfunction

endpackage

// File: rtl/num_ascii_serializer_bin2bcd.sv
// Sequential double-dabble converter: 32-bit unsigned in, 10-digit BCD out.
// o_done pulses exactly 32 cycles after an accepted i_start; o_bcd holds until the next start.
module bin2bcd_seq
    import num_ser_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    input  logic [CONV_BITS-1:0] i_bin,
    output logic                 o_done,
    output logic [BCD_WIDTH-1:0] o_bcd
);

    logic [CONV_BITS-1:0] r_bin;
    logic [BCD_WIDTH-1:0] r_bcd;
    logic [4:0]           r_cnt;
    logic                 r_busy;
    logic                 r_done;
    logic [BCD_WIDTH-1:0] w_adj;

    assign w_adj  = dabble_adjust(r_bcd);
    assign o_done = r_done;
    assign o_bcd  = r_bcd;

    // The first shift happens on the start edge (an all-zero BCD never needs
    // correction), so the remaining 31 shifts land done on cycle start+32.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bin  <= '0;
            r_bcd  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (!r_busy) begin
                if (i_start) begin
                    r_bcd  <= {{(BCD_WIDTH-1){1'b0}}, i_bin[CONV_BITS-1]};
                    r_bin  <= {i_bin[CONV_BITS-2:0], 1'b0};
                    r_cnt  <= 5'd31;
                    r_busy <= 1'b1;
                end
            end else begin
                r_bcd <= {w_adj[BCD_WIDTH-2:0], r_bin[CONV_BITS-1]};
                r_bin <= {r_bin[CONV_BITS-2:0], 1'b0};
                r_cnt <= r_cnt - 5'd1;
                if (r_cnt == 5'd1) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/num_ascii_serializer.sv
// Reads num_count signed integers from a registered RAM and streams them as
// decimal ASCII separated by SEP_CHAR over a valid/ready byte interface.
// Define NUM_SER_CRLF_EN to append CR LF after the last number.
module num_ascii_serializer
    import num_ser_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 11,
    parameter logic [7:0]  SEP_CHAR   = 8'h20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   num_count,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready
);

    localparam logic [ADDR_WIDTH:0] IDX_ONE = (ADDR_WIDTH+1)'(1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH:0]   r_count;
    logic [ADDR_WIDTH:0]   r_idx;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic                  r_neg;
    logic [3:0]            r_dig_ptr;
    logic                  r_done;

    logic                  w_done_nxt;
    logic                  w_last;
    logic                  w_conv_start;
    logic                  w_conv_done;
    logic [31:0]           w_ext;
    logic [31:0]           w_mag;
    logic [BCD_WIDTH-1:0]  w_bcd;
    logic [3:0]            w_msd;

    assign busy    = (r_state != ST_IDLE);
    assign done    = r_done;
    assign rd_addr = r_rd_addr;
    assign w_last  = ((r_idx + IDX_ONE) == r_count);
    assign w_ext   = 32'($signed(rd_data));
    assign w_mag   = rd_data[DATA_WIDTH-1] ? (~w_ext + 32'd1) : w_ext;

    bin2bcd_seq u_bcd (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_conv_start),
        .i_bin   (w_mag),
        .o_done  (w_conv_done),
        .o_bcd   (w_bcd)
    );

    // Locate the most significant non-zero digit; all-zero selects digit 0
    always_comb begin
        w_msd = '0;
        for (int unsigned d = 0; d < BCD_DIGITS; d++) begin
            if (w_bcd[4*d +: 4] != 4'd0) begin
                w_msd = 4'(d);
            end
        end
    end

    // Next-state decode and byte presentation
    always_comb begin
        w_state_nxt  = r_state;
        w_done_nxt   = 1'b0;
        w_conv_start = 1'b0;
        tx_valid     = 1'b0;
        tx_data      = '0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (num_count == '0) begin
`ifdef NUM_SER_CRLF_EN
                        w_state_nxt = ST_TAIL_CR;
`else
                        w_done_nxt  = 1'b1;
`endif
                    end else begin
                        w_state_nxt = ST_RD_REQ;
                    end
                end
            end
            ST_RD_REQ:  w_state_nxt = ST_RD_WAIT;
            ST_RD_WAIT: w_state_nxt = ST_LOAD;
            ST_LOAD: begin
                w_conv_start = 1'b1;
                w_state_nxt  = ST_CONV;
            end
            ST_CONV: begin
                if (w_conv_done) begin
                    w_state_nxt = r_neg ? ST_EMIT_SIGN : ST_EMIT_DIG;
                end
            end
            ST_EMIT_SIGN: begin
                tx_valid = 1'b1;
                tx_data  = ASCII_MINUS;
                if (tx_ready) w_state_nxt = ST_EMIT_DIG;
            end
            ST_EMIT_DIG: begin
                tx_valid = 1'b1;
                tx_data  = ASCII_ZERO + {4'b0000, w_bcd[{r_dig_ptr, 2'b00} +: 4]};
                if (tx_ready && r_dig_ptr == 4'd0) begin
                    if (!w_last) begin
                        w_state_nxt = ST_EMIT_SEP;
                    end else begin
`ifdef NUM_SER_CRLF_EN
                        w_state_nxt = ST_TAIL_CR;
`else
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
`endif
                    end
                end
            end
            ST_EMIT_SEP: begin
                tx_valid = 1'b1;
                tx_data  = SEP_CHAR;
                if (tx_ready) w_state_nxt = ST_RD_REQ;
            end
`ifdef NUM_SER_CRLF_EN
            ST_TAIL_CR: begin
                tx_valid = 1'b1;
                tx_data  = ASCII_CR;
                if (tx_ready) w_state_nxt = ST_TAIL_LF;
            end
            ST_TAIL_LF: begin
                tx_valid = 1'b1;
                tx_data  = ASCII_LF;
                if (tx_ready) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
`endif
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register, index/address counters, sign and digit pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_count   <= '0;
            r_idx     <= '0;
            r_rd_addr <= '0;
            r_neg     <= 1'b0;
            r_dig_ptr <= '0;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_count <= num_count;
                        r_idx   <= '0;
                        if (num_count != '0) r_rd_addr <= '0;
                    end
                end
                ST_LOAD: r_neg <= rd_data[DATA_WIDTH-1];
                ST_CONV: begin
                    if (w_conv_done) r_dig_ptr <= w_msd;
                end
                ST_EMIT_DIG: begin
                    if (tx_ready && r_dig_ptr != 4'd0) r_dig_ptr <= r_dig_ptr - 4'd1;
                end
                ST_EMIT_SEP: begin
                    if (tx_ready) begin
                        r_idx     <= r_idx + IDX_ONE;
                        r_rd_addr <= ADDR_WIDTH'(r_idx + IDX_ONE);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
